skintone_stream_ctrl: RTL and testbench

Flow controller wrapped around the 16-stage skintone datapath, which cannot stall. It accepts a frame of YCbCr pixels on a valid/ready stream and issues them into the datapath. Issue is credit-limited so every result is guaranteed a slot in an internal result FIFO. It then delivers scores downstream on a valid/ready stream and signals frame completion. It holds the start/busy/done contract for the frame sequencer above it.

---
 rtl/skintone_stream_ctrl_if.sv | 26 ++
 rtl/skintone_stream_ctrl.sv | 136 +++++++++++++
 tb/tb_skintone_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/skintone_stream_ctrl_if.sv
// Stream bundle between the skintone flow controller, its pixel source,
// the fixed-latency datapath and the score sink.
interface skintone_stream_ctrl_if;
    logic [23:0] pix_in;
    logic        pix_in_valid;
    logic        pix_in_ready;
    logic [23:0] dp_pixel;
    logic        dp_pixel_valid;
    logic [7:0]  dp_result;
    logic        dp_result_valid;
    logic [7:0]  res_out;
    logic        res_out_valid;
    logic        res_out_ready;

    // Controller side
    modport slave (
        input  pix_in, pix_in_valid, dp_result, dp_result_valid, res_out_ready,
        output pix_in_ready, dp_pixel, dp_pixel_valid, res_out, res_out_valid
    );

    // Environment side: pixel source, datapath and score sink
    modport master (
        output pix_in, pix_in_valid, dp_result, dp_result_valid, res_out_ready,
        input  pix_in_ready, dp_pixel, dp_pixel_valid, res_out, res_out_valid
    );
endinterface

// File: rtl/skintone_stream_ctrl.sv
// Credit-limited flow controller around the non-stallable skintone datapath.
// Optional per-frame skin statistics are built when SKINTONE_SKIN_STATS_EN is defined.
module skintone_stream_ctrl #(
    parameter int         DP_LATENCY  = 16,
    parameter int         FIFO_DEPTH  = 32,
    parameter int         LEN_W       = 20,
    parameter logic [7:0] SKIN_THRESH = 8'd128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [LEN_W-1:0] skin_count,
    skintone_stream_ctrl_if.slave strm
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FL_W  = $clog2(DP_LATENCY + 1);
    localparam int SUM_W = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;

    typedef enum logic [2:0] {FLUSH, IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [FL_W-1:0]  flush_cnt;
    logic [LEN_W-1:0] frame_len_q, issued, received, inflight;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             accept, xfer, push, store, pop, full, credit;

    assign accept   = (state == IDLE) && start;
    assign inflight = issued - received;
    // Every issued pixel must already own a FIFO slot when its result lands
    assign credit   = (SUM_W'(inflight) + SUM_W'(count)) < SUM_W'(FIFO_DEPTH);

    assign strm.pix_in_ready  = (state == RUN) && (issued < frame_len_q) && credit;
    assign xfer               = strm.pix_in_valid && strm.pix_in_ready;
    assign push               = strm.dp_result_valid && (state != FLUSH);
    assign full               = count == CNT_W'(FIFO_DEPTH);
    assign store              = push && (!full || pop);
    assign strm.res_out_valid = count != '0;
    assign strm.res_out       = mem[rd_ptr];
    assign pop                = strm.res_out_valid && strm.res_out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= FLUSH;
            flush_cnt           <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            frame_len_q         <= '0;
            issued              <= '0;
            strm.dp_pixel       <= '0;
            strm.dp_pixel_valid <= 1'b0;
        end else begin
            done                <= 1'b0;
            strm.dp_pixel_valid <= 1'b0;
            if (xfer) begin
                strm.dp_pixel       <= strm.pix_in;
                strm.dp_pixel_valid <= 1'b1;
                issued              <= issued + 1'b1;
            end
            case (state)
                FLUSH: begin
                    if (flush_cnt == FL_W'(DP_LATENCY - 1)) state <= IDLE;
                    else flush_cnt <= flush_cnt + 1'b1;
                end
                IDLE: begin
                    if (start) begin
                        frame_len_q <= frame_len;
                        issued      <= '0;
                        busy        <= 1'b1;
                        state       <= (frame_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (issued == frame_len_q) state <= DRAIN;
                end
                DRAIN: begin
                    if (received == frame_len_q && count == '0) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= strm.dp_result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            received <= '0;
            overflow <= 1'b0;
        end else begin
            if (store) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)   rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !store) overflow <= 1'b1;
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept)    received <= '0;
            else if (push) received <= received + 1'b1;
        end
    end

`ifdef SKINTONE_SKIN_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skin_count <= '0;
        end else if (accept) begin
            skin_count <= '0;
        end else if (pop && strm.res_out >= SKIN_THRESH && skin_count != '1) begin
            skin_count <= skin_count + 1'b1;
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^SKIN_THRESH;
    assign skin_count    = '0;
`endif

endmodule

// File: tb/tb_skintone_stream_ctrl.sv
// Randomized bench for skintone_stream_ctrl: fixed-latency datapath model plus
// an in-order score queue and per-frame transfer/pop/done accounting.
module tb_skintone_stream_ctrl;
    localparam int DP_LATENCY = 16;
    localparam int FIFO_DEPTH = 32;
    localparam int LEN_W      = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             busy, done, overflow;
    logic [LEN_W-1:0] skin_count;

    skintone_stream_ctrl_if bus();

    skintone_stream_ctrl #(
        .DP_LATENCY (DP_LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (LEN_W),
        .SKIN_THRESH(8'd128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .skin_count(skin_count),
        .strm      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] score_of(input logic [23:0] p);
        return p[23:16] ^ p[7:0];
    endfunction

    // Datapath stand-in: fixed latency, no reset, so strobes survive a DUT reset
    logic [24:0] dp_pipe [DP_LATENCY] = '{default: '0};
    logic        force_rv = 1'b1;
    always @(posedge clk) begin
        dp_pipe[0] <= {bus.dp_pixel_valid, bus.dp_pixel};
        for (int i = 1; i < DP_LATENCY; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign bus.dp_result_valid = force_rv | dp_pipe[DP_LATENCY-1][24];
    assign bus.dp_result       = score_of(dp_pipe[DP_LATENCY-1][23:0]);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard, sampled on the falling edge
    logic [7:0] exp_q [$];
    int cyc = 0, n_xfer = 0, n_pop = 0, n_done = 0, exp_skin = 0;
    int first_xfer = -1, last_xfer = -1, first_rv = -1, start_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (bus.res_out_valid && bus.res_out_ready) begin
                check_eq("queue_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check_eq("res_out", bus.res_out, e);
                    if (e >= 8'd128) exp_skin++;
                end
                n_pop++;
            end
            if (bus.pix_in_valid && bus.pix_in_ready) begin
                exp_q.push_back(score_of(bus.pix_in));
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                n_xfer++;
            end
            if (first_rv < 0 && first_xfer >= 0 && bus.res_out_valid) first_rv = cyc;
            if (start) start_cyc = cyc;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check_eq("busy_with_done", busy, 0);
            end
            check_eq("credit_bound", 32'(exp_q.size() <= FIFO_DEPTH), 1);
        end
    end

    logic [7:0] stat_scores [4] = '{8'd0, 8'd127, 8'd128, 8'd255};

    task automatic drive(input int pv_pct, input bit rr, input bit fixed, input int xbase);
        bus.pix_in_valid  = ($urandom_range(0, 99) < pv_pct);
        bus.res_out_ready = rr;
        bus.pix_in = fixed ? {stat_scores[(n_xfer - xbase) % 4], 8'h55, 8'h00} : 24'($urandom);
    endtask

    task automatic run_frame(input int len, input int pv_pct, input int rr_pct, input bit fixed,
                             input int restart_at, input int hold, input string name);
        int xb, pb, db, budget;
        bit timed_out;
        xb = n_xfer; pb = n_pop; db = n_done;
        exp_skin = 0; first_xfer = -1; first_rv = -1;
        @(posedge clk); #1;
        start = 1'b1; frame_len = LEN_W'(len);
        drive(pv_pct, $urandom_range(0, 99) < rr_pct && hold == 0, fixed, xb);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({name, "_busy_rise"}, busy, 1);
        budget = len * 40 + 300;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (n_done != db) begin
                timed_out = 1'b0;
                break;
            end
            if (hold > 0 && c == hold) begin
                check_eq({name, "_held_xfers"}, n_xfer - xb, FIFO_DEPTH);
                check_eq({name, "_held_ready"}, bus.pix_in_ready, 0);
                check_eq({name, "_held_full"}, bus.res_out_valid, 1);
                check_eq({name, "_held_ovf"}, overflow, 0);
            end
            drive(pv_pct, (c >= hold) && ($urandom_range(0, 99) < rr_pct), fixed, xb);
            start     = (c == restart_at);
            frame_len = (c == restart_at) ? LEN_W'(5) : LEN_W'(len);
            @(posedge clk); #1;
        end
        bus.pix_in_valid = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq({name, "_timeout"}, timed_out, 0);
        check_eq({name, "_xfers"}, n_xfer - xb, len);
        check_eq({name, "_pops"}, n_pop - pb, len);
        check_eq({name, "_done_pulses"}, n_done - db, 1);
        check_eq({name, "_busy_after"}, busy, 0);
        check_eq({name, "_queue_empty"}, exp_q.size(), 0);
        check_eq({name, "_ovf"}, overflow, 0);
`ifdef SKINTONE_SKIN_STATS_EN
        check_eq({name, "_skin"}, skin_count, exp_skin);
`else
        check_eq({name, "_skin"}, skin_count, 0);
`endif
    endtask

    initial begin
        bus.pix_in = '0; bus.pix_in_valid = 1'b0; bus.res_out_ready = 1'b1;

        // Reset held 3 edges, then 16 FLUSH cycles, with dp_result_valid forced high throughout
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_ovf", overflow, 0);
            check_eq("rst_ready", bus.pix_in_ready, 0);
            check_eq("rst_dp_pixel", bus.dp_pixel, 0);
            check_eq("rst_dp_valid", bus.dp_pixel_valid, 0);
            check_eq("rst_res_valid", bus.res_out_valid, 0);
            check_eq("rst_skin", skin_count, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < DP_LATENCY; i++) begin
            @(posedge clk); @(negedge clk);
            check_eq("flush_res_valid", bus.res_out_valid, 0);
            check_eq("flush_ready", bus.pix_in_ready, 0);
            check_eq("flush_ovf", overflow, 0);
        end
        force_rv = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_res_valid", bus.res_out_valid, 0);
        check_eq("idle_busy", busy, 0);

        // Full-rate streaming frame
        run_frame(100, 100, 100, 1'b0, -1, 0, "stream");
        // Transfer edge, then 1 + DP_LATENCY edges to the result strobe, then the push edge
        check_eq("stream_first_latency", first_rv - first_xfer, DP_LATENCY + 2);
        check_eq("stream_back_to_back", last_xfer - first_xfer, 99);

        // Sink stalled until the credit limit has frozen issue
        run_frame(64, 100, 100, 1'b0, -1, 80, "backpressure");

        // Zero-length frame
        run_frame(0, 100, 100, 1'b0, -1, 0, "zero_len");
        check_eq("zero_len_done_delay", done_cyc - start_cyc, 2);

        // Start while running must not retarget the frame
        run_frame(40, 100, 100, 1'b0, 10, 0, "restart_ignored");

        // Skin statistics over known scores
        run_frame(4, 100, 100, 1'b1, -1, 0, "stats");

        for (int f = 0; f < 4; f++) run_frame($urandom_range(1, 60), 70, 60, 1'b0, -1, 0, "rand");
        run_frame(50, 90, 15, 1'b0, -1, 0, "rand_slow_sink");

        // Reset after 10 transfers; their results must be swallowed by FLUSH
        begin
            int xb;
            bit reached;
            xb = n_xfer;
            reached = 1'b0;
            @(posedge clk); #1;
            start = 1'b1; frame_len = LEN_W'(50);
            drive(100, 1'b1, 1'b0, xb);
            for (int c = 0; c < 100; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (n_xfer - xb >= 10) begin
                    reached = 1'b1;
                    break;
                end
                drive(100, 1'b1, 1'b0, xb);
            end
            check_eq("midrst_reached", reached, 1);
            check_eq("midrst_xfers", n_xfer - xb, 10);
            rst = 1'b0;
            bus.pix_in_valid = 1'b0;
            #1;
            exp_q.delete();
            check_eq("midrst_busy", busy, 0);
            check_eq("midrst_ready", bus.pix_in_ready, 0);
            check_eq("midrst_dp_valid", bus.dp_pixel_valid, 0);
            check_eq("midrst_dp_pixel", bus.dp_pixel, 0);
            check_eq("midrst_res_valid", bus.res_out_valid, 0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            for (int i = 0; i < DP_LATENCY + 4; i++) begin
                @(negedge clk);
                check_eq("midrst_flush_res_valid", bus.res_out_valid, 0);
                check_eq("midrst_flush_ovf", overflow, 0);
            end
        end
        run_frame(30, 80, 70, 1'b0, -1, 0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
